fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised decoupled fetch front-end for the pipelined CPU. It replaces the single fetch-to-decode register with an N-entry instruction prefetch queue.
- Owns the PC and issues requests to a synchronous-read instruction memory (1-cycle latency). It buffers {instr, pc, next_pc} tuples and hands them to decode over a valid/ready handshake.
- Supports branch redirect with queue flush, and halt detection that stops further fetching.

Parameters:
- INSTR_W, 16, instruction width in bits
- ADDR_W, 16, PC / instruction address width in bits
- DEPTH, 4, queue entries; a power of two, at least 2
- PC_STEP, 2, byte increment between sequential instructions
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- redirect  in  1  branch taken or PC override from decode/execute
- redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1
- imem_req  out  1  read request to instruction memory this cycle
- imem_addr  out  ADDR_W  read address; equals pc_q
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_req
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode accepts the head entry (0 = stall)
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  address of the head instruction
- out_next_pc  out  ADDR_W  out_pc + PC_STEP, modulo 2^ADDR_W
- count  out  $clog2(DEPTH+1)  current number of queue entries
- fetch_halted  out  1  a halt opcode was captured; fetching is stopped

Behaviour:
- Reset (asynchronous): pc_q=RESET_PC, inflight_q=0, count=0, halt_q=0, read/write pointers=0.
  - All outputs at reset: out_valid=0, imem_req=0, fetch_halted=0, count=0, imem_addr=RESET_PC.
  - out_instr, out_pc and out_next_pc at reset equal entry 0 contents, which are cleared to 0.
- Request rule: imem_req = !redirect && !halt_q && (count + inflight_q < DEPTH). This is a credit check, so the queue can never overflow.
- When imem_req=1:
  - pc_q <= pc_q + PC_STEP, wrapping modulo 2^ADDR_W;
  - inflight_q <= 1, holding the address that was issued.
- When imem_req=0 and no redirect: inflight_q <= 0 and pc_q holds.
- Capture: at the end of the cycle after a request (inflight_q=1) and with redirect=0, push {imem_rdata, inflight_addr, inflight_addr+PC_STEP}.
- Pop: when out_valid && out_ready, the read pointer advances.
  - Push and pop in the same cycle: count unchanged.
  - Pop when empty: impossible, since out_valid=0.
- Redirect (takes priority over everything except reset):
  - queue flushed (count=0, pointers=0);
  - pending response dropped (inflight_q <= 0);
  - no request that cycle;
  - pc_q <= redirect_pc;
  - halt_q <= 0.
  - Fetch resumes the next cycle. A redirect costs exactly 1 request bubble.
  - A pop presented in the redirect cycle is ignored; decode must treat it as squashed.
- Halt: if a captured instruction has [INSTR_W-1:INSTR_W-4] == HALT_OP, halt_q <= 1 in the same edge as the push.
  - The halt instruction itself is queued and delivered normally.
  - No further requests are issued while halt_q=1.
  - fetch_halted = halt_q.
- Stall: with out_ready=0, the queue fills to DEPTH and imem_req drops.
  - Entries are never lost or reordered.
  - Head outputs are stable while out_valid && !out_ready.
- Wrap-around: read and write pointers wrap modulo DEPTH; pc_q wraps modulo 2^ADDR_W.
- Latency: the first instruction after reset or redirect reaches out_valid 2 cycles after its request cycle starts (request, capture, visible).
- Invariant for assertions: count + inflight_q <= DEPTH at all times.

Decomposition:
- Shared package cpu_pkg holds:
  - HALT_OP = 4'hF;
  - the opcode width constant;
  - the default PC_STEP;
  - a packed struct type fetch_entry_t {instr, pc, next_pc}, which the decode and pipeline registers reuse.
- One sub-module, fetch_fifo: a parametrised circular buffer of DEPTH entries with push, pop, flush, count, and head read.
- The top level holds the PC, the inflight tracking, the halt logic, and the request/credit logic.

Test Plan:
- Reset, then out_ready=1, with a memory model returning {4'h1, addr[11:0]}: imem_addr sequence 0,2,4,…; first out_valid in cycle 2 with out_instr=16'h1000, out_pc=0, out_next_pc=2; then one instruction per cycle.
- out_ready=0 from reset: count reaches 4 and imem_req goes 0 with pc_q=8. Then release: out_pc is delivered in order 0,2,4,6, then requests resume at 8.
- Redirect=1, redirect_pc=16'h0040 while count=3 and a request is in flight: next cycle count=0, out_valid=0, and the stale response is not pushed. Then imem_addr=16'h0040, and out_pc=16'h0040 appears 2 cycles later.
- Memory returns 16'hF000 at addr 6: that entry is delivered and fetch_halted=1; no imem_req after it. Then redirect to 16'h0010: fetch_halted=0 and fetching resumes.
- PC wrap: RESET_PC=16'hFFFE gives imem_addr FFFE then 0000, and out_next_pc for FFFE is 0000.
- Assert rst mid-stream with count=2 and inflight=1: all outputs clear immediately (async). After release, fetch restarts at RESET_PC with no stale entries.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcode fields, the halt encoding and the fetch tuple
// handed from fetch to decode and down the pipeline registers.
package cpu_pkg;

    localparam int OPCODE_W    = 4;
    localparam int INSTR_W_DEF = 16;
    localparam int ADDR_W_DEF  = 16;
    localparam int PC_STEP_DEF = 2;

    localparam logic [OPCODE_W-1:0] HALT_OP = 4'hF;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
        logic [ADDR_W_DEF-1:0]  next_pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of DEPTH entries with push, pop, flush and a combinational head read.
// Zero-latency head; no internal backpressure, the caller's credit check keeps it from overflowing.
module fetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_data = mem[rd_ptr];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front-end: owns the PC, issues 1-cycle imem reads and queues {instr, pc, next_pc}.
// Request to out_valid is 2 cycles; requests are credit-gated so a stalled decode never loses entries.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int                INSTR_W  = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_next_pc,
    output logic [CNT_W-1:0]   count,
    output logic               fetch_halted
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  next_pc;
    } entry_t;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_addr_q;
    logic              inflight_q;
    logic              halt_q;
    logic [CNT_W-1:0]  used;
    logic              push;
    logic              pop;
    logic              is_halt;
    entry_t            push_entry;
    entry_t            head_entry;

    // An in-flight read already owns a slot, so it counts against the credit.
    assign used     = count + CNT_W'(inflight_q);
    assign imem_req = !rst && !redirect && !halt_q && (used < CNT_W'(DEPTH));
    assign imem_addr = pc_q;

    assign push      = inflight_q && !redirect;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect;
    assign is_halt   = (imem_rdata[INSTR_W-1 -: OPCODE_W] == HALT_OP);

    assign push_entry.instr   = imem_rdata;
    assign push_entry.pc      = inflight_addr_q;
    assign push_entry.next_pc = inflight_addr_q + STEP;

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign out_instr    = head_entry.instr;
    assign out_pc       = head_entry.pc;
    assign out_next_pc  = head_entry.next_pc;
    assign fetch_halted = halt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            halt_q          <= 1'b0;
        end else if (redirect) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            if (imem_req) begin
                pc_q            <= pc_q + STEP;
                inflight_q      <= 1'b1;
                inflight_addr_q <= pc_q;
            end else begin
                inflight_q <= 1'b0;
            end
            if (push && is_halt) begin
                halt_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, stall/fill, redirect flush, halt, PC wrap, async reset.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_next_pc;
    logic [2:0]  count;
    logic        fetch_halted;
    logic [15:0] halt_addr;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(
        .INSTR_W  (16),
        .ADDR_W   (16),
        .DEPTH    (4),
        .PC_STEP  (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_next_pc  (out_next_pc),
        .count        (count),
        .fetch_halted (fetch_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data = {1, addr[11:0]}, or a halt word at halt_addr.
    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata <= (imem_addr == halt_addr) ? 16'hF000 : {4'h1, imem_addr[11:0]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        out_ready   = 1'b1;
        halt_addr   = 16'hFFFF;
        #3;
        chk("rst_valid",  out_valid, 0);
        chk("rst_req",    imem_req, 0);
        chk("rst_halted", fetch_halted, 0);
        chk("rst_count",  count, 0);
        chk("rst_addr",   imem_addr, 16'h0000);
        chk("rst_instr",  out_instr, 0);
        chk("rst_pc",     out_pc, 0);
        chk("rst_npc",    out_next_pc, 0);

        // Streaming with decode always ready
        tick();
        rst = 1'b0;
        #1;
        chk("s_req0",  imem_req, 1);
        chk("s_addr0", imem_addr, 16'h0000);
        tick();
        chk("s_addr1",  imem_addr, 16'h0002);
        chk("s_valid1", out_valid, 0);
        tick();
        chk("s_valid2", out_valid, 1);
        chk("s_instr2", out_instr, 16'h1000);
        chk("s_pc2",    out_pc, 16'h0000);
        chk("s_npc2",   out_next_pc, 16'h0002);
        chk("s_cnt2",   count, 1);
        tick();
        chk("s_pc3",    out_pc, 16'h0002);
        chk("s_instr3", out_instr, 16'h1002);
        tick();
        chk("s_pc4",    out_pc, 16'h0004);

        // Asynchronous reset mid-stream with two entries queued and one read in flight
        out_ready = 1'b0;
        tick();
        chk("ar_cnt_before", count, 2);
        rst = 1'b1;
        #1;
        chk("ar_valid",  out_valid, 0);
        chk("ar_count",  count, 0);
        chk("ar_req",    imem_req, 0);
        chk("ar_addr",   imem_addr, 16'h0000);
        chk("ar_pc",     out_pc, 0);
        chk("ar_instr",  out_instr, 0);

        // Stall from reset: queue fills to DEPTH and requests stop at pc 8
        tick();
        rst = 1'b0;
        #1;
        chk("st_req0",  imem_req, 1);
        chk("st_addr0", imem_addr, 16'h0000);
        tick(); tick(); tick(); tick();
        chk("st_cnt3", count, 3);
        chk("st_req3", imem_req, 0);
        tick();
        chk("st_cnt4",  count, 4);
        chk("st_req4",  imem_req, 0);
        chk("st_addr4", imem_addr, 16'h0008);
        chk("st_pc4",   out_pc, 16'h0000);
        tick();
        chk("st_hold_pc",    out_pc, 16'h0000);
        chk("st_hold_instr", out_instr, 16'h1000);
        chk("st_hold_cnt",   count, 4);

        out_ready = 1'b1;
        #1;
        chk("rl_pc0", out_pc, 16'h0000);
        tick();
        chk("rl_pc1",  out_pc, 16'h0002);
        chk("rl_req",  imem_req, 1);
        chk("rl_addr", imem_addr, 16'h0008);
        tick();
        chk("rl_pc2", out_pc, 16'h0004);
        tick();
        chk("rl_pc3", out_pc, 16'h0006);
        tick();
        chk("rl_pc4", out_pc, 16'h0008);

        // Redirect with three entries queued and a read in flight
        out_ready = 1'b0;
        tick();
        chk("rd_cnt_pre", count, 3);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        out_ready   = 1'b1;
        #1;
        chk("rd_req_bubble", imem_req, 0);
        tick();
        redirect = 1'b0;
        #1;
        chk("rd_cnt0",  count, 0);
        chk("rd_valid", out_valid, 0);
        chk("rd_addr",  imem_addr, 16'h0040);
        chk("rd_req",   imem_req, 1);
        tick();
        chk("rd_stale_cnt", count, 0);
        chk("rd_addr1",     imem_addr, 16'h0042);
        tick();
        chk("rd_valid2", out_valid, 1);
        chk("rd_pc2",    out_pc, 16'h0040);
        chk("rd_instr2", out_instr, 16'h1040);

        // Halt word at address 6
        halt_addr   = 16'h0006;
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        #1;
        chk("h_addr0", imem_addr, 16'h0000);
        tick(); tick(); tick(); tick();
        chk("h_pre_halted", fetch_halted, 0);
        tick();
        chk("h_pc",      out_pc, 16'h0006);
        chk("h_instr",   out_instr, 16'hF000);
        chk("h_halted",  fetch_halted, 1);
        chk("h_req",     imem_req, 0);
        chk("h_addr",    imem_addr, 16'h000A);
        tick();
        chk("h_tail_pc", out_pc, 16'h0008);
        chk("h_req2",    imem_req, 0);
        tick();
        chk("h_empty",   out_valid, 0);
        chk("h_req3",    imem_req, 0);
        chk("h_halted3", fetch_halted, 1);

        halt_addr   = 16'hFFFF;
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        #1;
        chk("hr_halted", fetch_halted, 0);
        chk("hr_req",    imem_req, 1);
        chk("hr_addr",   imem_addr, 16'h0010);
        tick(); tick();
        chk("hr_pc", out_pc, 16'h0010);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        #1;
        chk("w_addr0", imem_addr, 16'hFFFE);
        tick();
        chk("w_addr1", imem_addr, 16'h0000);
        tick();
        chk("w_pc",    out_pc, 16'hFFFE);
        chk("w_npc",   out_next_pc, 16'h0000);
        chk("w_instr", out_instr, 16'h1FFE);
        tick();
        chk("w_pc1",   out_pc, 16'h0000);
        chk("w_npc1",  out_next_pc, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
